// File: rtl/bsg_cycle_counter_bank.sv
// Bank of independent event counters with an atomic snapshot file that is
// drained one channel at a time through a valid/ready port with a one-entry buffer.
module bsg_cycle_counter_bank #(
   parameter  int width_p    = 32,
   parameter  int els_p      = 4,
   parameter  int saturate_p = 0,
   localparam int lg_els_lp  = (els_p == 1) ? 1 : $clog2(els_p)
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [els_p-1:0]           en_i,
   input  logic [els_p-1:0]           clear_i,
   input  logic                       freeze_i,
   input  logic                       snapshot_i,
   input  logic                       v_i,
   input  logic [lg_els_lp-1:0]       addr_i,
   output logic                       ready_o,
   output logic                       v_o,
   output logic [width_p-1:0]         data_o,
   output logic                       ovf_o,
   input  logic                       yumi_i,
   output logic [els_p*width_p-1:0]   ctr_r_o
);

   localparam int pad_els_lp = 1 << lg_els_lp;

   logic [width_p-1:0] ctr_reg      [els_p];
   logic [width_p-1:0] ctr_next     [els_p];
   logic               ovf_reg      [els_p];
   logic               ovf_next     [els_p];
   logic [width_p-1:0] snap_reg     [els_p];
   logic               snap_ovf_reg [els_p];

   // Read mux is padded to a power of two so unused addresses return zero.
   logic [width_p-1:0] snap_pad     [pad_els_lp];
   logic               snap_ovf_pad [pad_els_lp];

   logic               v_reg;
   logic [width_p-1:0] data_reg;
   logic               ovf_out_reg;
   logic               accept;

   genvar gi;

   for (gi = 0; gi < els_p; gi++) begin : g_ctr
      logic inc;
      logic at_max;
      assign inc    = en_i[gi] & ~freeze_i;
      assign at_max = &ctr_reg[gi];
      assign ctr_next[gi] = clear_i[gi]                ? '0 :
                            ~inc                       ? ctr_reg[gi] :
                            (at_max && saturate_p != 0) ? ctr_reg[gi] :
                                                         ctr_reg[gi] + width_p'(1);
      assign ovf_next[gi] = clear_i[gi] ? 1'b0 : (ovf_reg[gi] | (inc & at_max));
      assign ctr_r_o[gi*width_p +: width_p] = ctr_reg[gi];
   end

   for (gi = 0; gi < pad_els_lp; gi++) begin : g_pad
      if (gi < els_p) begin : g_real
         assign snap_pad[gi]     = snap_reg[gi];
         assign snap_ovf_pad[gi] = snap_ovf_reg[gi];
      end else begin : g_zero
         assign snap_pad[gi]     = '0;
         assign snap_ovf_pad[gi] = 1'b0;
      end
   end

   // Snapshot samples the pre-update counters, so same-edge clears are not seen.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < els_p; i++) begin
            ctr_reg[i]      <= '0;
            ovf_reg[i]      <= 1'b0;
            snap_reg[i]     <= '0;
            snap_ovf_reg[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < els_p; i++) begin
            ctr_reg[i] <= ctr_next[i];
            ovf_reg[i] <= ovf_next[i];
            if (snapshot_i) begin
               snap_reg[i]     <= ctr_reg[i];
               snap_ovf_reg[i] <= ovf_reg[i];
            end
         end
      end
   end

   assign ready_o = ~v_reg | yumi_i;
   assign accept  = v_i & ready_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         v_reg       <= 1'b0;
         data_reg    <= '0;
         ovf_out_reg <= 1'b0;
      end else if (accept) begin
         v_reg       <= 1'b1;
         data_reg    <= snap_pad[addr_i];
         ovf_out_reg <= snap_ovf_pad[addr_i];
      end else if (yumi_i) begin
         v_reg       <= 1'b0;
      end
   end

   assign v_o    = v_reg;
   assign data_o = data_reg;
   assign ovf_o  = ovf_out_reg;

endmodule

// File: doc/bsg_cycle_counter_bank.md
Name: bsg_cycle_counter_bank

Overview:
A bank of els_p independent event/cycle counters, each width_p bits wide, with per-channel count enable and synchronous clear.
- Global freeze and selectable wrap or saturate on overflow.
- Sticky per-channel overflow flags.
- A snapshot register file read back through a valid/ready port with a one-entry output buffer.
- Used for performance monitoring in tiles and network links: software or debug logic snapshots all counters atomically, then drains them one channel at a time.

Parameters:
width_p, 32, counter width in bits (>=1)
els_p, 4, number of counter channels (>=1)
saturate_p, 0, 0 = counters wrap to 0 past all-ones; 1 = counters hold at all-ones
lg_els_lp (derived, not overridable), els_p==1 ? 1 : clog2(els_p), read address width

Ports:
clk_i  in  1  clock, all state on rising edge
reset_i  in  1  reset, asynchronous, active-high
en_i  in  els_p  per-channel count enable; bit i increments counter i this cycle
clear_i  in  els_p  per-channel synchronous clear of counter i and its overflow flag
freeze_i  in  1  global hold; when 1 no counter increments (clear still acts)
snapshot_i  in  1  copy all live counters and overflow flags into the snapshot file
v_i  in  1  read request valid
addr_i  in  lg_els_lp  channel to read from the snapshot file
ready_o  out  1  read request accepted when v_i & ready_o
v_o  out  1  read response valid
data_o  out  width_p  snapshot counter value of the requested channel
ovf_o  out  1  snapshot overflow flag of the requested channel
yumi_i  in  1  consumer takes the response; legal only when v_o=1
ctr_r_o  out  els_p*width_p  live counters, channel i at bits [i*width_p +: width_p]

Behaviour:
- Reset (async assert, released synchronously by the environment): all counters 0, overflow flags 0, snapshot file 0, v_o=0, data_o=0, ovf_o=0. Resetting mid-operation discards any pending response.
- Counter i, priority per cycle:
  - clear_i[i]: counter <= 0 and ovf[i] <= 0.
  - else en_i[i] & ~freeze_i: increment.
  - else hold.
- Increment at all-ones:
  - saturate_p=0: counter goes to 0 and ovf[i] <= 1.
  - saturate_p=1: counter stays at all-ones and ovf[i] <= 1.
  - ovf[i] is sticky until clear_i[i] or reset.
- width_p=1: the counter toggles in wrap mode; in saturate mode it sticks at 1 with ovf set on the second increment.
- ctr_r_o is the registered state; an increment is visible one cycle after en_i is sampled.
- Snapshot: on an edge with snapshot_i=1, snap[i] <= pre-update ctr[i] and snap_ovf[i] <= pre-update ovf[i] for every i, atomically.
  - Same-cycle clear_i or increment does not affect the captured value.
  - The snapshot file changes only on snapshot_i or reset.
- Read port:
  - ready_o = ~v_o | yumi_i, combinational from registered v_o and yumi_i.
  - On accept (v_i & ready_o), at the next edge: v_o <= 1, data_o <= snap[addr_i], ovf_o <= snap_ovf[addr_i]. Latency is 1 cycle.
  - yumi_i with no new accept: v_o <= 0 and data_o holds its last value.
  - Back-to-back accept with yumi_i sustains 1 read per cycle.
  - While v_o=1 and yumi_i=0, data_o and ovf_o are stable.
- Simultaneous snapshot_i and read accept: the read returns the old snapshot contents; the new snapshot is visible to reads accepted from the next cycle.
- addr_i >= els_p (non-power-of-two els_p): the response is data_o=0, ovf_o=0, v_o=1; no error signalled.
- freeze_i does not block snapshot, clear or reads.

Test Plan:
- Reset then en_i=all-ones for 5 cycles -> ctr_r_o every channel = 5; assert reset_i mid-count -> all counters 0 immediately, without waiting for a clock edge.
- width_p=4, saturate_p=0, channel 0 enabled 17 cycles -> counter = 1; snapshot, read addr 0 -> data_o=1, ovf_o=1. Repeat with saturate_p=1 -> data_o=15, ovf_o=1.
- Channel 2 counting, with clear_i[2], snapshot_i and en_i[2] in the same cycle at count 9 -> read addr 2 returns 9 with its pre-clear ovf; live counter = 0 next cycle, ovf cleared.
- freeze_i=1 for 3 of 10 enabled cycles -> counter = 7; clear_i during freeze -> 0.
- Reads to addr 0,1,2,3 on consecutive cycles with yumi_i tied to v_o -> 4 responses in 4 cycles, in order. Hold yumi_i=0 for 3 cycles -> ready_o=0, data_o stable, no request lost.
- els_p=3: read addr 3 -> v_o=1, data_o=0, ovf_o=0.
